// File: rtl/machine_timer_responder_if.sv
// Data-bus request/response bundle between the LSU-side decode and the
// machine timer responder.
interface machine_timer_responder_if #(
    parameter int DW    = 32,
    parameter int ADDRW = 5
);
    logic             req_i;
    logic             cs_i;
    logic             we_i;
    logic [3:0]       mask_i;
    logic [ADDRW-1:0] addr_i;
    logic [DW-1:0]    wdata_i;
    logic [DW-1:0]    rdata_o;
    logic             ack_o;
    logic             err_o;

    modport master (
        output req_i, cs_i, we_i, mask_i, addr_i, wdata_i,
        input  rdata_o, ack_o, err_o
    );

    modport slave (
        input  req_i, cs_i, we_i, mask_i, addr_i, wdata_i,
        output rdata_o, ack_o, err_o
    );
endinterface

// File: rtl/machine_timer_responder.sv
// Memory-mapped mtime/mtimecmp responder with prescaled counting,
// atomic high-word snapshot and a level timer interrupt.
module machine_timer_responder #(
    parameter int DW    = 32,
    parameter int ADDRW = 5,
    parameter int PSW   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    machine_timer_responder_if.slave   bus,
    output logic                       t_intr_o
);
    localparam logic [2:0] A_MTLO = 3'd0;
    localparam logic [2:0] A_MTHI = 3'd1;
    localparam logic [2:0] A_CPLO = 3'd2;
    localparam logic [2:0] A_CPHI = 3'd3;
    localparam logic [2:0] A_CTRL = 3'd4;
    localparam logic [2:0] A_STAT = 3'd5;

    logic [2*DW-1:0] mtime_q, mtime_d;
    logic [2*DW-1:0] cmp_q, cmp_d;
    logic            en_q, en_d;
    logic [PSW-1:0]  ps_q, ps_d;
    logic [PSW-1:0]  presc_q, presc_d;
    logic [DW-1:0]   snap_q, snap_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            intr_q, intr_d;

    logic            acc, wr, rd, tick;
    logic [2:0]      idx;
    logic [DW-1:0]   ctrl_rd, ctrl_wr;

    function automatic logic [DW-1:0] bmerge(
        input logic [DW-1:0] o,
        input logic [DW-1:0] n,
        input logic [3:0]    m
    );
        logic [DW-1:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = m[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    assign acc     = bus.req_i & bus.cs_i;
    assign wr      = acc & bus.we_i;
    assign rd      = acc & ~bus.we_i;
    assign idx     = bus.addr_i[ADDRW-1:2];
    assign tick    = en_q && (presc_q == ps_q);
    assign ctrl_rd = {16'h0, ps_q, 7'h0, en_q};
    assign ctrl_wr = bmerge(ctrl_rd, bus.wdata_i, bus.mask_i);

    always_comb begin
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        presc_d = presc_q;
        if (en_q)
            presc_d = tick ? '0 : presc_q + 1'b1;
        cmp_d   = cmp_q;
        en_d    = en_q;
        ps_d    = ps_q;
        snap_d  = snap_q;
        rdata_d = '0;
        err_d   = 1'b0;
        ack_d   = acc;

        // A software write to one mtime half suppresses that cycle's tick
        if (wr) begin
            case (idx)
                A_MTLO: mtime_d = {mtime_q[2*DW-1:DW],
                    bmerge(mtime_q[DW-1:0], bus.wdata_i, bus.mask_i)};
                A_MTHI: mtime_d = {bmerge(mtime_q[2*DW-1:DW],
                    bus.wdata_i, bus.mask_i), mtime_q[DW-1:0]};
                A_CPLO: cmp_d[DW-1:0] =
                    bmerge(cmp_q[DW-1:0], bus.wdata_i, bus.mask_i);
                A_CPHI: cmp_d[2*DW-1:DW] =
                    bmerge(cmp_q[2*DW-1:DW], bus.wdata_i, bus.mask_i);
                A_CTRL: begin
                    en_d    = ctrl_wr[0];
                    ps_d    = ctrl_wr[15:8];
                    presc_d = '0;
                end
                default: err_d = 1'b1;
            endcase
        end

        if (rd) begin
            case (idx)
                A_MTLO: begin
                    rdata_d = mtime_q[DW-1:0];
                    snap_d  = mtime_q[2*DW-1:DW];
                end
                A_MTHI: rdata_d = snap_q;
                A_CPLO: rdata_d = cmp_q[DW-1:0];
                A_CPHI: rdata_d = cmp_q[2*DW-1:DW];
                A_CTRL: rdata_d = ctrl_rd;
                A_STAT: rdata_d = {{(DW-1){1'b0}}, intr_q};
                default: err_d = 1'b1;
            endcase
        end

        intr_d = (mtime_d >= cmp_d);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mtime_q <= '0;
            cmp_q   <= '1;
            en_q    <= 1'b0;
            ps_q    <= '0;
            presc_q <= '0;
            snap_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            intr_q  <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            ps_q    <= ps_d;
            presc_q <= presc_d;
            snap_q  <= snap_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            intr_q  <= intr_d;
        end
    end

    assign bus.rdata_o = rdata_q;
    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign t_intr_o    = intr_q;
endmodule

// File: tb/tb_machine_timer_responder.sv
// Directed plus randomized checks of the machine timer responder
// against a cycle-level behavioural model of the register map.
module tb_machine_timer_responder;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic t_intr_o;

    machine_timer_responder_if bus ();

    machine_timer_responder dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .bus     (bus),
        .t_intr_o(t_intr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_pass = 0;

    // Behavioural model state
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic        m_en;
    logic [7:0]  m_ps;
    int          m_cnt;
    logic [31:0] m_snap;
    logic        m_intr;
    logic        e_ack, e_err;
    logic [31:0] e_rd;
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] bm(input logic [31:0] o,
        input logic [31:0] n, input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = m[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_time = 64'd0;
        m_cmp  = '1;
        m_en   = 1'b0;
        m_ps   = 8'd0;
        m_cnt  = 0;
        m_snap = 32'd0;
        m_intr = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic c, input logic w,
        input logic [3:0] m, input logic [4:0] a, input logic [31:0] d);
        logic        acc, tick;
        int          idx;
        logic [63:0] nt, nc;
        logic [31:0] ctl;
        acc   = r & c;
        idx   = int'(a) / 4;
        e_ack = acc;
        e_rd  = 32'd0;
        e_err = 1'b0;
        tick  = m_en && (m_cnt == int'(m_ps));
        nt    = tick ? m_time + 64'd1 : m_time;
        nc    = m_cmp;
        ctl   = {16'h0, m_ps, 7'h0, m_en};
        if (m_en) m_cnt = tick ? 0 : m_cnt + 1;
        if (acc && !w) begin
            if (idx == 0) begin
                e_rd = m_time[31:0];
            end else if (idx == 1) e_rd = m_snap;
            else if (idx == 2) e_rd = m_cmp[31:0];
            else if (idx == 3) e_rd = m_cmp[63:32];
            else if (idx == 4) e_rd = ctl;
            else if (idx == 5) e_rd = {31'd0, m_intr};
            else e_err = 1'b1;
            if (idx == 0) m_snap = m_time[63:32];
        end
        if (acc && w) begin
            if (idx == 0) nt = {m_time[63:32], bm(m_time[31:0], d, m)};
            else if (idx == 1) nt = {bm(m_time[63:32], d, m), m_time[31:0]};
            else if (idx == 2) nc[31:0] = bm(m_cmp[31:0], d, m);
            else if (idx == 3) nc[63:32] = bm(m_cmp[63:32], d, m);
            else if (idx == 4) begin
                ctl   = bm(ctl, d, m);
                m_en  = ctl[0];
                m_ps  = ctl[15:8];
                m_cnt = 0;
            end else e_err = 1'b1;
        end
        m_time = nt;
        m_cmp  = nc;
        m_intr = (nt >= nc);
    endtask

    task automatic cyc(input logic r, input logic c, input logic w,
        input logic [3:0] m, input logic [4:0] a, input logic [31:0] d);
        bus.req_i   = r;
        bus.cs_i    = c;
        bus.we_i    = w;
        bus.mask_i  = m;
        bus.addr_i  = a;
        bus.wdata_i = d;
        @(posedge clk_i);
        model_step(r, c, w, m, a, d);
        #1;
        bus.req_i = 1'b0;
        chk("ack", bus.ack_o, e_ack);
        chk("rdata", bus.rdata_o, e_rd);
        chk("err", bus.err_o, e_err);
        chk("intr", t_intr_o, m_intr);
        last_rd = bus.rdata_o;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, 1'b1, 4'hF, a, d);
    endtask

    task automatic rd(input logic [4:0] a);
        cyc(1'b1, 1'b1, 1'b0, 4'h0, a, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 1'b0, 4'h0, 5'h0, 32'h0);
    endtask

    initial begin
        bus.req_i   = 1'b0;
        bus.cs_i    = 1'b0;
        bus.we_i    = 1'b0;
        bus.mask_i  = 4'h0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ack", bus.ack_o, 1'b0);
        chk("rst_rdata", bus.rdata_o, 32'd0);
        chk("rst_err", bus.err_o, 1'b0);
        chk("rst_intr", t_intr_o, 1'b0);
        rst_i = 1'b1;

        rd(5'h08);
        chk("rst_cmplo", last_rd, 32'hFFFF_FFFF);
        rd(5'h0C);
        chk("rst_cmphi", last_rd, 32'hFFFF_FFFF);

        cyc(1'b1, 1'b1, 1'b1, 4'b0101, 5'h08, 32'hAABB_CCDD);
        rd(5'h08);
        chk("bytemask", last_rd, 32'hFFBB_FFDD);
        cyc(1'b1, 1'b1, 1'b1, 4'b0000, 5'h0C, 32'h1234_5678);
        rd(5'h0C);
        chk("mask0_noop", last_rd, 32'hFFFF_FFFF);

        wr(5'h10, 32'h0000_0301);
        idle(40);
        rd(5'h00);
        chk("count40", (last_rd >= 32'd9 && last_rd <= 32'd11), 1'b1);
        rd(5'h10);
        chk("ctrl_rb", last_rd, 32'h0000_0301);

        wr(5'h10, 32'h0);
        wr(5'h04, 32'h0);
        wr(5'h00, 32'hFFFF_FFFE);
        wr(5'h10, 32'h0000_0001);
        idle(3);
        rd(5'h00);
        rd(5'h04);
        chk("carry_snap", last_rd, 32'd1);

        wr(5'h10, 32'h0);
        wr(5'h00, 32'h0);
        wr(5'h04, 32'h0);
        wr(5'h0C, 32'h0);
        wr(5'h08, 32'd20);
        wr(5'h10, 32'h0000_0001);
        for (int i = 0; i < 100 && t_intr_o !== 1'b1; i++) idle(1);
        chk("intr_rise", t_intr_o, 1'b1);
        rd(5'h00);
        chk("intr_at20", last_rd, 32'd20);
        wr(5'h08, 32'd100);
        chk("intr_fall", t_intr_o, 1'b0);

        wr(5'h10, 32'h0);
        rd(5'h14);
        chk("stat_pre", last_rd, 32'd0);
        wr(5'h14, 32'hFFFF_FFFF);
        chk("wr_ro_err", bus.err_o, 1'b1);
        rd(5'h18);
        chk("unmap_err", bus.err_o, 1'b1);
        chk("unmap_rd0", last_rd, 32'd0);
        rd(5'h14);
        chk("stat_post", last_rd, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 5'h08, 32'h0);
        chk("cs0_noack", bus.ack_o, 1'b0);
        rd(5'h00);
        rd(5'h08);
        chk("b2b_ack", bus.ack_o, 1'b1);

        bus.req_i  = 1'b1;
        bus.cs_i   = 1'b1;
        bus.we_i   = 1'b0;
        bus.addr_i = 5'h08;
        #2;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        bus.req_i = 1'b0;
        chk("rst_mid_ack", bus.ack_o, 1'b0);
        model_reset();
        rst_i = 1'b1;
        idle(1);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 4) != 0, ($urandom % 8) != 0,
                $urandom % 2, 4'($urandom),
                5'($urandom), ($urandom % 4 == 0) ? 32'($urandom % 64)
                                                  : $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
